// File: rtl/cross_bar_pkg.sv
// Shared crossbar definitions: operation encodings and command-word field layout,
// used by both the request initiator and the responder side.
package cross_bar_pkg;

  localparam logic RD_OPP = 1'b0;
  localparam logic WR_OPP = 1'b1;

  // Command word layout: {cmd, addr, wdata}, with wdata in the LSBs.
  localparam int WDATA_LSB = 0;

  function automatic int addr_lsb(input int dwidth);
    return dwidth;
  endfunction

  function automatic int cmd_pos(input int awidth, input int dwidth);
    return awidth + dwidth;
  endfunction

endpackage

// File: rtl/req_initiator_if.sv
// Base request/acknowledge bus between an initiator (master) and a responder (slave).
interface req_initiator_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req;
  logic              cmd;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              ack;
  logic [DWIDTH-1:0] rdata;

  modport master (output req, cmd, addr, wdata, input ack, rdata);
  modport slave  (input req, cmd, addr, wdata, output ack, rdata);
endinterface

// File: rtl/req_timeout_timer.sv
// Counts cycles while enabled and flags when TIMEOUT_MAX has been reached;
// the count saturates there so it can never wrap back into a false "not expired".
module req_timeout_timer #(
  parameter int TIMEOUT_MAX = 15
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_MAX) + 1;

  logic [TW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn)                count <= '0;
    else if (clear)              count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

  assign expired = (count == TW'(TIMEOUT_MAX));

endmodule

// File: rtl/req_initiator.sv
// Pops commands from a FIFO and issues them on the req/ack bus, capturing read
// data, flagging timeouts and waiting for ack to drop before taking the next command.
module req_initiator
  import cross_bar_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT_MAX = 15
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     fifo_empty,
  input  logic [AWIDTH+DWIDTH:0]   fifo_dout,
  output logic                     fifo_rd_en,
  req_initiator_if.master          bus,
  output logic [DWIDTH-1:0]        rdata_out,
  output logic                     rdata_valid,
  output logic                     err,
  output logic                     busy
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, REQ, WAIT_ACK_LOW} state_e;

  localparam int CMD_POS  = cmd_pos(AWIDTH, DWIDTH);
  localparam int ADDR_LSB = addr_lsb(DWIDTH);

  state_e            state_q, state_d;
  logic              expired;
  logic              cmd_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment first means every path assigns state_d, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (!fifo_empty) state_d = FETCH;
      FETCH:        state_d = LOAD;
      LOAD:         state_d = REQ;
      REQ:          if (bus.ack || expired) state_d = WAIT_ACK_LOW;
      WAIT_ACK_LOW: if (!bus.ack) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  req_timeout_timer #(.TIMEOUT_MAX(TIMEOUT_MAX)) u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (state_q != REQ),
    .enable  (state_q == REQ),
    .expired (expired)
  );

  // fifo_dout is only valid in LOAD, one cycle after the FETCH pop.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cmd_q   <= RD_OPP;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == LOAD) begin
      cmd_q   <= fifo_dout[CMD_POS];
      addr_q  <= fifo_dout[ADDR_LSB +: AWIDTH];
      wdata_q <= fifo_dout[WDATA_LSB +: DWIDTH];
    end
  end

  // An ack on the same edge as expiry still completes normally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      if (state_q == REQ) begin
        if (bus.ack) begin
          if (cmd_q == RD_OPP) begin
            rdata_out   <= bus.rdata;
            rdata_valid <= 1'b1;
          end
        end else if (expired) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign fifo_rd_en = (state_q == FETCH);
  assign busy       = (state_q != IDLE);
  assign bus.req    = (state_q == REQ);
  assign bus.cmd    = cmd_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator: a small FIFO model feeds commands and the
// initial block plays the responder, comparing against hand-computed expectations.
module tb_req_initiator;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          fifo_empty;
  logic [AW+DW:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] rdata_out;
  logic          rdata_valid;
  logic          err;
  logic          busy;

  req_initiator_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  req_initiator #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_MAX(15)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .bus         (bus),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .err         (err),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  // Command FIFO model: 16 entries, registered read data one cycle after the pop.
  logic [AW+DW:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int underflow = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge aclk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        underflow <= underflow + 1;
      end else begin
        fifo_dout <= mem[rd_ptr % 16];
        rd_ptr    <= rd_ptr + 1;
        pop_cnt   <= pop_cnt + 1;
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic push(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem[wr_ptr % 16] = {c, a, d};
    wr_ptr++;
  endtask

  // Plays one transaction as the responder. ack_at = req-high cycle on which ack
  // is raised (0 = never), hold = extra cycles ack stays high after req falls.
  task automatic run_txn(input int ack_at, input int hold, input logic [DW-1:0] rd_val,
                         output int lat, output int hi, output int rv, output int er,
                         output int wait_pops, output int tail, output logic [AW+DW:0] word);
    int n;
    lat = 0; hi = 0; rv = 0; er = 0; wait_pops = 0; tail = 0; word = '0;
    while (!bus.req && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.req) begin
      check("req_rise_bound", {127'd0, bus.req}, 128'd1);
      return;
    end
    word = {bus.cmd, bus.addr, bus.wdata};
    while (bus.req && hi < 40) begin
      hi++;
      if (hi == ack_at) begin
        bus.ack   = 1'b1;
        bus.rdata = rd_val;
      end
      tick();
      rv += int'(rdata_valid);
      er += int'(err);
    end
    tail = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      tail++;
      wait_pops += int'(fifo_rd_en);
      rv += int'(rdata_valid);
      er += int'(err);
    end
    bus.ack = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      tail++;
      rv += int'(rdata_valid);
      er += int'(err);
    end
    check("busy_fall_bound", {127'd0, busy}, 128'd0);
  endtask

  int lat, hi, rv, er, wp, tail, prev_tail, pops0;
  logic [AW+DW:0] word;

  initial begin
    aresetn   = 1'b0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    repeat (3) tick();
    check("rst_flags", {123'd0, bus.req, fifo_rd_en, rdata_valid, err, busy}, 128'd0);
    check("rst_regs", {bus.cmd, bus.addr, bus.wdata, rdata_out}, 128'd0);
    aresetn = 1'b1;

    // Ack while idle with an empty FIFO must not start anything.
    bus.ack = 1'b1;
    repeat (3) tick();
    check("idle_ack_busy", {127'd0, busy}, 128'd0);
    check("idle_ack_pops", pop_cnt, 0);
    bus.ack = 1'b0;
    tick();

    // Read, ack on 4th req cycle.
    push(1'b0, 32'h10, 32'h0);
    run_txn(4, 0, 32'hCAFE_0001, lat, hi, rv, er, wp, tail, word);
    check("rd_latency", lat, 3);
    check("rd_req_cycles", hi, 4);
    check("rd_cmd", {127'd0, word[AW+DW]}, 128'd0);
    check("rd_addr", word[DW +: AW], 32'h10);
    check("rd_valid_pulses", rv, 1);
    check("rd_err", er, 0);
    check("rd_data", rdata_out, 32'hCAFE_0001);

    // Write, ack on 2nd req cycle: rdata_out must hold.
    push(1'b1, 32'h20, 32'hDEAD);
    run_txn(2, 0, 32'h5555_5555, lat, hi, rv, er, wp, tail, word);
    check("wr_cmd", {127'd0, word[AW+DW]}, 128'd1);
    check("wr_addr", word[DW +: AW], 32'h20);
    check("wr_wdata", word[DW-1:0], 32'hDEAD);
    check("wr_req_cycles", hi, 2);
    check("wr_valid_pulses", rv, 0);
    check("wr_rdata_hold", rdata_out, 32'hCAFE_0001);

    // Timeout: no ack at all.
    push(1'b0, 32'h30, 32'h0);
    run_txn(0, 0, 32'h0, lat, hi, rv, er, wp, tail, word);
    check("to_req_cycles", hi, 16);
    check("to_err_pulses", er, 1);
    check("to_valid_pulses", rv, 0);

    // Next command proceeds; ack coincides with expiry and wins.
    push(1'b0, 32'h40, 32'h0);
    run_txn(16, 0, 32'h1234_5678, lat, hi, rv, er, wp, tail, word);
    check("tie_latency", lat, 3);
    check("tie_req_cycles", hi, 16);
    check("tie_err", er, 0);
    check("tie_valid_pulses", rv, 1);
    check("tie_data", rdata_out, 32'h1234_5678);

    // Stretched ack with another command already queued.
    push(1'b0, 32'h50, 32'h0);
    push(1'b1, 32'h60, 32'hBEEF);
    run_txn(2, 5, 32'hAAAA_0000, lat, hi, rv, er, wp, tail, word);
    check("late_wait_pops", wp, 0);
    check("late_valid_pulses", rv, 1);
    check("late_data", rdata_out, 32'hAAAA_0000);
    run_txn(1, 0, 32'h0, lat, hi, rv, er, wp, tail, word);
    check("late_next_latency", lat, 3);
    check("late_next_addr", word[DW +: AW], 32'h60);

    // Back-to-back: three queued reads.
    pops0 = pop_cnt;
    push(1'b0, 32'h70, 32'h0);
    push(1'b0, 32'h71, 32'h0);
    push(1'b0, 32'h72, 32'h0);
    prev_tail = 0;
    for (int i = 0; i < 3; i++) begin
      run_txn(1, 0, 32'h100 + i, lat, hi, rv, er, wp, tail, word);
      check($sformatf("b2b_addr%0d", i), word[DW +: AW], 32'h70 + i);
      check($sformatf("b2b_data%0d", i), rdata_out, 32'h100 + i);
      if (i > 0) check($sformatf("b2b_gap%0d", i), {127'd0, (prev_tail + lat - 1) >= 3}, 128'd1);
      prev_tail = tail;
    end
    check("b2b_pops", pop_cnt - pops0, 3);

    // Reset while req is high; the popped command is lost.
    pops0 = pop_cnt;
    push(1'b1, 32'h80, 32'h1);
    lat = 0;
    while (!bus.req && lat < 40) begin
      tick();
      lat++;
    end
    check("rst_mid_req_seen", {127'd0, bus.req}, 128'd1);
    aresetn = 1'b0;
    tick();
    check("rst_mid_flags", {126'd0, bus.req, busy}, 128'd0);
    check("rst_mid_regs", {bus.cmd, bus.addr, bus.wdata, rdata_out}, 128'd0);
    aresetn = 1'b1;
    bus.ack = 1'b1;
    repeat (3) tick();
    check("rst_spurious_busy", {127'd0, busy}, 128'd0);
    check("rst_no_replay", pop_cnt - pops0, 1);
    check("rst_fifo_empty", {127'd0, fifo_empty}, 128'd1);
    bus.ack = 1'b0;
    tick();

    check("no_underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
